// File: rtl/mlaccel_pkg.sv
// Shared constants and types for the mlaccel host interface.
package mlaccel_pkg;

    localparam logic [7:0] CMD_STATUS     = 8'h20;
    localparam logic [7:0] CMD_WRITE_CODE = 8'h21;
    localparam logic [7:0] CMD_RUN        = 8'h23;
    localparam logic [7:0] CMD_ACCESS     = 8'h25;

    localparam logic [7:0] UNDERRUN_BYTE_DFLT = 8'hFF;

    typedef enum logic [1:0] {
        IDLE,
        RX,
        TX
    } state_e;

endpackage

// File: rtl/mlaccel_qpi_sync.sv
// Input synchroniser for the QPI pins: IN_STAGES flops, a delayed copy, and edge strobes.
module mlaccel_qpi_sync #(
    parameter int unsigned IN_STAGES = 1
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       i_qpi_csb,
    input  logic       i_qpi_clk,
    input  logic [3:0] i_qpi_di,
    output logic       o_csb,
    output logic       o_clk_rise,
    output logic       o_clk_fall,
    output logic       o_csb_rise,
    output logic       o_csb_fall,
    output logic [3:0] o_nibble
);
    // Sample layout {csb, clk, di}; reset to the bus idle state so no edge fires on release.
    localparam logic [5:0] IDLE_SAMPLE = 6'b11_0000;

    logic [IN_STAGES-1:0][5:0] r_stage;
    logic [5:0]                r_dly;
    logic [5:0]                w_cur;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_stage <= {IN_STAGES{IDLE_SAMPLE}};
            r_dly   <= IDLE_SAMPLE;
        end else begin
            r_stage[0] <= {i_qpi_csb, i_qpi_clk, i_qpi_di};
            for (int unsigned i = 1; i < IN_STAGES; i++) begin
                r_stage[i] <= r_stage[i-1];
            end
            r_dly <= w_cur;
        end
    end

    assign w_cur      = r_stage[IN_STAGES-1];
    assign o_csb      = w_cur[5];
    assign o_clk_rise = w_cur[4] & ~r_dly[4];
    assign o_clk_fall = ~w_cur[4] & r_dly[4];
    assign o_csb_rise = w_cur[5] & ~r_dly[5];
    assign o_csb_fall = ~w_cur[5] & r_dly[5];
    // The delayed copy holds the io value of the phase that just ended.
    assign o_nibble   = r_dly[3:0];

endmodule

// File: rtl/mlaccel_qpi_phy.sv
// Byte-level QPI slave PHY: assembles host nibble pairs into bytes and serialises decoder
// bytes back onto the io pins for readback opcodes.
module mlaccel_qpi_phy
    import mlaccel_pkg::*;
#(
    parameter logic [7:0]  UNDERRUN_BYTE = UNDERRUN_BYTE_DFLT,
    parameter int unsigned IN_STAGES     = 1
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       qpi_csb,
    input  logic       qpi_clk,
    input  logic [3:0] qpi_di,
    output logic [3:0] qpi_do,
    output logic       qpi_oe,
    output logic       rx_start,
    output logic       rx_valid,
    output logic [7:0] rx_data,
    output logic       rx_stop,
    input  logic       tx_en,
    input  logic       tx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_ready,
    output logic       tx_underrun
);
    state_e     r_state, w_state_d;
    logic       w_csb, w_clk_rise, w_clk_fall, w_csb_rise, w_csb_fall;
    logic [3:0] w_nibble;

    logic       r_half, w_half_d;
    logic       r_first, w_first_d;
    logic [3:0] r_hi, w_hi_d;
    logic [7:0] r_tx_byte, w_tx_byte_d;
    logic [3:0] r_do, w_do_d;
    logic       r_oe, w_oe_d;
    logic       r_rx_valid, w_rx_valid_d;
    logic       r_rx_start, w_rx_start_d;
    logic       r_rx_stop, w_rx_stop_d;
    logic [7:0] r_rx_data, w_rx_data_d;

    logic       w_active, w_restart, w_load, w_rx_hi, w_rx_byte, w_tx_lo, w_tx_exit;
    logic [7:0] w_tx_next;

    mlaccel_qpi_sync #(
        .IN_STAGES (IN_STAGES)
    ) u_sync (
        .clock      (clock),
        .resetn     (resetn),
        .i_qpi_csb  (qpi_csb),
        .i_qpi_clk  (qpi_clk),
        .i_qpi_di   (qpi_di),
        .o_csb      (w_csb),
        .o_clk_rise (w_clk_rise),
        .o_clk_fall (w_clk_fall),
        .o_csb_rise (w_csb_rise),
        .o_csb_fall (w_csb_fall),
        .o_nibble   (w_nibble)
    );

    // csb dominates: any sample with csb high or a fresh select masks clk edges.
    assign w_active  = ~w_csb & ~w_csb_fall & (r_state != IDLE);
    assign w_restart = ~w_csb & ((r_state == IDLE) | w_csb_fall);
    assign w_load    = w_active & w_clk_fall & tx_en & ((r_state == TX) | ~r_half);
    // With tx_en up the host is in its turnaround cycle, so rises carry no data.
    assign w_rx_hi   = w_active & (r_state == RX) & w_clk_rise & ~tx_en;
    assign w_rx_byte = w_active & (r_state == RX) & w_clk_fall & r_half;
    assign w_tx_lo   = w_active & (r_state == TX) & w_clk_rise;
    assign w_tx_exit = w_active & (r_state == TX) & w_clk_fall & ~tx_en;
    assign w_tx_next = tx_valid ? tx_data : UNDERRUN_BYTE;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_d;
        end
    end

    always_comb begin
        w_state_d = r_state;
        if (w_csb) begin
            w_state_d = IDLE;
        end else if (w_restart) begin
            w_state_d = RX;
        end else if (w_load) begin
            w_state_d = TX;
        end else if (w_tx_exit) begin
            w_state_d = RX;
        end
    end

    always_comb begin
        w_half_d     = r_half;
        w_first_d    = r_first;
        w_hi_d       = r_hi;
        w_tx_byte_d  = r_tx_byte;
        w_do_d       = r_do;
        w_oe_d       = r_oe;
        w_rx_valid_d = 1'b0;
        w_rx_start_d = 1'b0;
        w_rx_stop_d  = w_csb_rise & (r_state != IDLE);
        w_rx_data_d  = r_rx_data;
        tx_ready     = w_load & tx_valid;
        tx_underrun  = w_load & ~tx_valid;

        if (w_csb | w_restart) begin
            w_half_d  = 1'b0;
            w_oe_d    = 1'b0;
            w_do_d    = 4'h0;
            w_first_d = w_restart;
        end
        if (w_load) begin
            w_tx_byte_d = w_tx_next;
            w_do_d      = w_tx_next[7:4];
            w_oe_d      = 1'b1;
            w_half_d    = 1'b0;
        end
        if (w_tx_lo) begin
            w_do_d = r_tx_byte[3:0];
        end
        if (w_tx_exit) begin
            w_oe_d   = 1'b0;
            w_do_d   = 4'h0;
            w_half_d = 1'b0;
        end
        if (w_rx_hi) begin
            w_hi_d   = w_nibble;
            w_half_d = 1'b1;
        end
        if (w_rx_byte) begin
            w_rx_valid_d = 1'b1;
            w_rx_start_d = r_first;
            w_rx_data_d  = {r_hi, w_nibble};
            w_first_d    = 1'b0;
            w_half_d     = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_half     <= 1'b0;
            r_first    <= 1'b0;
            r_hi       <= 4'h0;
            r_tx_byte  <= 8'h00;
            r_do       <= 4'h0;
            r_oe       <= 1'b0;
            r_rx_valid <= 1'b0;
            r_rx_start <= 1'b0;
            r_rx_stop  <= 1'b0;
            r_rx_data  <= 8'h00;
        end else begin
            r_half     <= w_half_d;
            r_first    <= w_first_d;
            r_hi       <= w_hi_d;
            r_tx_byte  <= w_tx_byte_d;
            r_do       <= w_do_d;
            r_oe       <= w_oe_d;
            r_rx_valid <= w_rx_valid_d;
            r_rx_start <= w_rx_start_d;
            r_rx_stop  <= w_rx_stop_d;
            r_rx_data  <= w_rx_data_d;
        end
    end

    assign qpi_do   = r_do;
    assign qpi_oe   = r_oe;
    assign rx_valid = r_rx_valid;
    assign rx_start = r_rx_start;
    assign rx_stop  = r_rx_stop;
    assign rx_data  = r_rx_data;

endmodule

// File: tb/tb_mlaccel_qpi_phy.sv
// Directed bench for mlaccel_qpi_phy: the bench plays the QPI host and the command decoder.
module tb_mlaccel_qpi_phy;
    import mlaccel_pkg::*;

    localparam logic [7:0] TX_BYTES [3] = '{8'h05, 8'h03, 8'h00};

    logic       clock = 1'b0;
    logic       resetn = 1'b0;
    logic       qpi_csb = 1'b1;
    logic       qpi_clk = 1'b1;
    logic [3:0] qpi_di = 4'h0;
    logic [3:0] qpi_do;
    logic       qpi_oe;
    logic       rx_start, rx_valid, rx_stop;
    logic [7:0] rx_data;
    logic       tx_en = 1'b0;
    logic       tx_valid = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_ready, tx_underrun;

    int n_checks = 0;
    int n_pass = 0;

    int n_rxv = 0, n_rxs = 0, n_stop = 0, n_rdy = 0, n_unf = 0, n_oe = 0;
    logic [7:0] start_byte = 8'h00;
    logic [7:0] rx_q [$];
    int b_rxv, b_rxs, b_stop, b_rdy, b_unf, b_oe, b_q;

    logic offer_en = 1'b0;
    int   tx_idx = 0;

    mlaccel_qpi_phy #(
        .UNDERRUN_BYTE (8'hFF),
        .IN_STAGES     (1)
    ) dut (
        .clock       (clock),
        .resetn      (resetn),
        .qpi_csb     (qpi_csb),
        .qpi_clk     (qpi_clk),
        .qpi_di      (qpi_di),
        .qpi_do      (qpi_do),
        .qpi_oe      (qpi_oe),
        .rx_start    (rx_start),
        .rx_valid    (rx_valid),
        .rx_data     (rx_data),
        .rx_stop     (rx_stop),
        .tx_en       (tx_en),
        .tx_valid    (tx_valid),
        .tx_data     (tx_data),
        .tx_ready    (tx_ready),
        .tx_underrun (tx_underrun)
    );

    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (rx_valid) begin
            n_rxv++;
            rx_q.push_back(rx_data);
        end
        if (rx_start) begin
            n_rxs++;
            start_byte = rx_data;
        end
        if (rx_stop) n_stop++;
        if (tx_ready) n_rdy++;
        if (tx_underrun) n_unf++;
        if (qpi_oe) n_oe++;
    end

    // Decoder model: the offered byte advances one cycle after each accepted handshake.
    always begin : decoder
        logic hs;
        @(negedge clock);
        hs = tx_ready;
        @(posedge clock);
        #1;
        if (!offer_en) tx_idx = 0;
        else if (hs) tx_idx++;
        tx_valid = offer_en && (tx_idx < 3);
        tx_data  = (tx_idx < 3) ? TX_BYTES[tx_idx] : 8'h00;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic snap();
        b_rxv = n_rxv; b_rxs = n_rxs; b_stop = n_stop;
        b_rdy = n_rdy; b_unf = n_unf; b_oe = n_oe; b_q = rx_q.size();
    endtask

    function automatic logic [7:0] rx_at(input int i);
        return (i < rx_q.size()) ? rx_q[i] : 8'hxx;
    endfunction

    task automatic host_edge(input logic lvl, input logic [3:0] nib, input int half);
        qpi_clk = lvl;
        qpi_di  = nib;
        #(half);
    endtask

    task automatic host_send(input logic [7:0] b, input int half);
        host_edge(1'b0, b[7:4], half);
        host_edge(1'b1, b[3:0], half);
    endtask

    task automatic host_recv(input int half, output logic [7:0] b);
        qpi_clk = 1'b0;
        qpi_di  = 4'h0;
        #15;
        b[7:4] = qpi_do;
        #(half - 15);
        qpi_clk = 1'b1;
        #15;
        b[3:0] = qpi_do;
        #(half - 15);
    endtask

    // Command 0x20, a turnaround cycle, then three read bytes; edges sit 2 ns after a core
    // negedge so each pin update lands before the host's 15 ns sample point.
    task automatic status_read(input logic offer, input logic [7:0] exp_byte [3], input string tag);
        logic [7:0] got;
        offer_en = offer;
        tx_en = 1'b0;
        repeat (3) @(posedge clock);
        snap();
        @(negedge clock);
        #2;
        qpi_csb = 1'b0;
        #20;
        host_send(CMD_STATUS, 20);
        host_edge(1'b0, 4'h0, 20);
        tx_en = 1'b1;
        host_edge(1'b1, 4'h0, 20);
        for (int i = 0; i < 3; i++) begin
            host_recv(20, got);
            check($sformatf("%s_byte%0d", tag, i), {24'h0, got}, {24'h0, exp_byte[i]});
        end
        qpi_csb = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        check({tag, "_oe_after_csb"}, {31'h0, qpi_oe}, 32'h0);
        tx_en = 1'b0;
        repeat (4) @(posedge clock);
        #1;
        check({tag, "_rx_cmd"}, rx_at(b_q), {24'h0, CMD_STATUS});
        check({tag, "_rx_count"}, n_rxv - b_rxv, 1);
        check({tag, "_stop_count"}, n_stop - b_stop, 1);
        check({tag, "_ready_count"}, n_rdy - b_rdy, offer ? 3 : 0);
        check({tag, "_underrun_count"}, n_unf - b_unf, offer ? 0 : 3);
    endtask

    initial begin
        logic [7:0] got;
        logic [7:0] exp_rx [5];

        #23;
        check("rst_oe", {31'h0, qpi_oe}, 32'h0);
        check("rst_do", {28'h0, qpi_do}, 32'h0);
        check("rst_rx", {21'h0, rx_valid, rx_start, rx_stop, rx_data}, 32'h0);
        check("rst_tx", {30'h0, tx_ready, tx_underrun}, 32'h0);
        resetn = 1'b1;
        repeat (3) @(posedge clock);

        // Write-code command followed by a 32-bit word, all in receive direction.
        exp_rx = '{8'h21, 8'h01, 8'h00, 8'h08, 8'h00};
        snap();
        qpi_csb = 1'b0;
        #17;
        for (int i = 0; i < 5; i++) host_send(exp_rx[i], 17);
        host_edge(1'b0, 4'h0, 17);
        host_edge(1'b1, 4'h0, 17);
        qpi_csb = 1'b1;
        repeat (4) @(posedge clock);
        #1;
        check("wr_rx_count", n_rxv - b_rxv, 5);
        for (int i = 0; i < 5; i++) begin
            check($sformatf("wr_byte%0d", i), {24'h0, rx_at(b_q + i)}, {24'h0, exp_rx[i]});
        end
        check("wr_start_count", n_rxs - b_rxs, 1);
        check("wr_start_byte", {24'h0, start_byte}, 32'h21);
        check("wr_stop_count", n_stop - b_stop, 1);
        check("wr_oe_cycles", n_oe - b_oe, 0);

        status_read(1'b1, TX_BYTES, "stat");
        status_read(1'b0, '{8'hFF, 8'hFF, 8'hFF}, "unf");

        // Run command then a lone high nibble: the partial byte must vanish.
        snap();
        qpi_csb = 1'b0;
        #17;
        host_send(CMD_RUN, 17);
        host_edge(1'b0, 4'h4, 17);
        host_edge(1'b1, 4'h0, 17);
        qpi_csb = 1'b1;
        repeat (4) @(posedge clock);
        #1;
        check("part_rx_count", n_rxv - b_rxv, 1);
        check("part_byte", {24'h0, rx_at(b_q)}, {24'h0, CMD_RUN});
        check("part_stop_count", n_stop - b_stop, 1);

        // Reset while the PHY drives the low nibble of the second read byte.
        offer_en = 1'b1;
        repeat (3) @(posedge clock);
        @(negedge clock);
        #2;
        qpi_csb = 1'b0;
        #20;
        host_send(CMD_STATUS, 20);
        host_edge(1'b0, 4'h0, 20);
        tx_en = 1'b1;
        host_edge(1'b1, 4'h0, 20);
        host_recv(20, got);
        check("rst_mid_byte0", {24'h0, got}, 32'h05);
        host_edge(1'b0, 4'h0, 20);
        qpi_clk = 1'b1;
        #15;
        check("rst_mid_pre_oe", {31'h0, qpi_oe}, 32'h1);
        check("rst_mid_pre_do", {28'h0, qpi_do}, 32'h3);
        resetn = 1'b0;
        #1;
        check("rst_mid_oe", {31'h0, qpi_oe}, 32'h0);
        check("rst_mid_do", {28'h0, qpi_do}, 32'h0);
        qpi_csb = 1'b1;
        qpi_clk = 1'b1;
        tx_en = 1'b0;
        offer_en = 1'b0;
        #20;
        resetn = 1'b1;
        repeat (3) @(posedge clock);
        snap();
        qpi_csb = 1'b0;
        #17;
        host_send(CMD_ACCESS, 17);
        host_send(8'h00, 17);
        host_send(8'h00, 17);
        host_edge(1'b0, 4'h0, 17);
        host_edge(1'b1, 4'h0, 17);
        qpi_csb = 1'b1;
        repeat (4) @(posedge clock);
        #1;
        check("acc_rx_count", n_rxv - b_rxv, 3);
        check("acc_byte0", {24'h0, rx_at(b_q)}, {24'h0, CMD_ACCESS});
        check("acc_byte2", {24'h0, rx_at(b_q + 2)}, 32'h00);
        check("acc_start_count", n_rxs - b_rxs, 1);
        check("acc_start_byte", {24'h0, start_byte}, {24'h0, CMD_ACCESS});

        // Clock activity while deselected must be invisible.
        snap();
        for (int i = 0; i < 8; i++) begin
            qpi_clk = ~qpi_clk;
            qpi_di  = 4'(i);
            #17;
        end
        repeat (4) @(posedge clock);
        #1;
        check("desel_rxv", n_rxv - b_rxv, 0);
        check("desel_start", n_rxs - b_rxs, 0);
        check("desel_stop", n_stop - b_stop, 0);
        check("desel_ready", n_rdy - b_rdy, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
